// File: rtl/serial_word_loader.sv
// Assembles a start/data/stop framed, valid-qualified serial stream into an N-bit word
// and hands it to the downstream register with a one-cycle carga strobe.
module serial_word_loader #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_sync,
  input  logic         serial_in,
  input  logic         valid_in,
  output logic [N-1:0] word_out,
  output logic         carga,
  output logic         frame_error,
  output logic         busy
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic [N-1:0]   shreg_r;
  logic [N-1:0]   shreg_s;
  logic [N-1:0]   word_r;
  logic [N-1:0]   word_s;
  logic [CW-1:0]  cnt_r;
  logic [CW-1:0]  cnt_s;
  logic           carga_r;
  logic           carga_s;
  logic           ferr_r;
  logic           ferr_s;
  logic           busy_r;

  // State register
  always_ff @(posedge clk) begin
    if (reset_sync) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; every transition needs a valid beat, so gaps simply hold
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (valid_in) begin
          if (!serial_in) state_s = DATA;
          else            state_s = IDLE;
        end else begin
          state_s = IDLE;
        end
      end
      DATA: begin
        if (valid_in) begin
          if (cnt_r == CW'(N - 1)) state_s = STOP;
          else                     state_s = DATA;
        end else begin
          state_s = DATA;
        end
      end
      STOP: begin
        if (valid_in) state_s = IDLE;
        else          state_s = STOP;
      end
      default: state_s = IDLE;
    endcase
  end

  // Output and datapath next values; serial_in is only looked at under valid_in
  always_comb begin
    shreg_s = shreg_r;
    cnt_s   = cnt_r;
    word_s  = word_r;
    carga_s = 1'b0;
    ferr_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (valid_in) begin
          if (!serial_in) cnt_s = CW'(0);
          else            cnt_s = cnt_r;
        end else begin
          cnt_s = cnt_r;
        end
      end
      DATA: begin
        if (valid_in) begin
          shreg_s = {serial_in, shreg_r[N-1:1]};
          cnt_s   = cnt_r + CW'(1);
        end else begin
          shreg_s = shreg_r;
        end
      end
      STOP: begin
        if (valid_in) begin
          if (serial_in) begin
            word_s  = shreg_r;
            carga_s = 1'b1;
          end else begin
            ferr_s  = 1'b1;
          end
        end else begin
          word_s = word_r;
        end
      end
      default: begin
        carga_s = 1'b0;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset_sync) begin
      shreg_r <= '0;
      cnt_r   <= '0;
      word_r  <= '0;
      carga_r <= 1'b0;
      ferr_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      shreg_r <= shreg_s;
      cnt_r   <= cnt_s;
      word_r  <= word_s;
      carga_r <= carga_s;
      ferr_r  <= ferr_s;
      busy_r  <= (state_s != IDLE);
    end
  end

  assign word_out    = word_r;
  assign carga       = carga_r;
  assign frame_error = ferr_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed, table-driven bench for serial_word_loader (N=4), plus hand-written
// sequences for strobe latency/width and reset priority.
module tb_serial_word_loader;

  logic       clk_tb;
  logic       reset_sync;
  logic       serial_in;
  logic       valid_in;
  logic [3:0] word_out;
  logic       carga;
  logic       frame_error;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       rst;
    logic       v;
    logic       s;
    logic [3:0] w;
    logic       c;
    logic       f;
    logic       b;
  } vec_t;

  vec_t vecs[$];

  serial_word_loader #(.N(4)) dut (
    .clk         (clk_tb),
    .reset_sync  (reset_sync),
    .serial_in   (serial_in),
    .valid_in    (valid_in),
    .word_out    (word_out),
    .carga       (carga),
    .frame_error (frame_error),
    .busy        (busy)
  );

  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  task automatic add(input logic r, input logic v, input logic s, input logic [3:0] w,
                     input logic c, input logic f, input logic b);
    vec_t t;
    t.rst = r; t.v = v; t.s = s; t.w = w; t.c = c; t.f = f; t.b = b;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs and sample outputs 1 time unit after the edge
  task automatic beat(input logic r, input logic v, input logic s);
    reset_sync = r;
    valid_in   = v;
    serial_in  = s;
    @(posedge clk_tb);
    #1;
  endtask

  initial begin
    int cpulses;
    int fpulses;
    logic [3:0] bits_g;
    reset_sync = 1'b1;
    valid_in   = 1'b0;
    serial_in  = 1'b1;

    // Reset, then idle line
    add(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) add(1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);

    // Good frame 0|1,0,1,1|1 -> 4'hD
    add(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'hD, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 4'hD, 1'b0, 1'b0, 1'b0);

    // Same frame with 3 invalid cycles (serial_in = X) after each beat
    bits_g = 4'b1101;
    add(1'b0, 1'b1, 1'b0, 4'hD, 1'b0, 1'b0, 1'b1);
    for (int g = 0; g < 3; g++) add(1'b0, 1'b0, 1'bx, 4'hD, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      add(1'b0, 1'b1, bits_g[i], 4'hD, 1'b0, 1'b0, 1'b1);
      for (int g = 0; g < 3; g++) add(1'b0, 1'b0, 1'bx, 4'hD, 1'b0, 1'b0, 1'b1);
    end
    add(1'b0, 1'b1, 1'b1, 4'hD, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'bx, 4'hD, 1'b0, 1'b0, 1'b0);

    // Framing error 0|0,1,1,0|0: word stays 4'hD
    add(1'b0, 1'b1, 1'b0, 4'hD, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 4'hD, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'hD, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'hD, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 4'hD, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 4'hD, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 4'hD, 1'b0, 1'b0, 1'b0);

    // Back-to-back 0|0,0,1,0|1 then 0|1,1,1,1|1
    add(1'b0, 1'b1, 1'b0, 4'hD, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 4'hD, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 4'hD, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'hD, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 4'hD, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h4, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'h4, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 1'b1, 4'h4, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);

    // Reset mid-frame, then 0|1,0,0,0|1 -> 4'h1
    add(1'b0, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0);

    @(negedge clk_tb);
    foreach (vecs[i]) begin
      beat(vecs[i].rst, vecs[i].v, vecs[i].s);
      check("word_out", i, 32'(word_out), 32'(vecs[i].w));
      check("carga", i, 32'(carga), 32'(vecs[i].c));
      check("frame_error", i, 32'(frame_error), 32'(vecs[i].f));
      check("busy", i, 32'(busy), 32'(vecs[i].b));
    end

    // Frame 0|1,0,1,0|1 -> 4'h5: strobe right after stop edge, single pulse
    beat(1'b0, 1'b1, 1'b0);
    bits_g = 4'b0101;
    for (int i = 0; i < 4; i++) beat(1'b0, 1'b1, bits_g[i]);
    beat(1'b0, 1'b1, 1'b1);
    check("lat_carga", 0, 32'(carga), 32'd1);
    check("lat_word", 0, 32'(word_out), 32'h5);
    cpulses = 0;
    fpulses = 0;
    for (int i = 0; i < 8; i++) begin
      beat(1'b0, 1'b0, 1'b0);
      if (carga === 1'b1) cpulses++;
      if (frame_error === 1'b1) fpulses++;
    end
    check("extra_carga", 0, 32'(cpulses), 32'd0);
    check("extra_ferr", 0, 32'(fpulses), 32'd0);
    check("hold_word", 0, 32'(word_out), 32'h5);

    // Reset priority: framed beats during reset are ignored
    beat(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      beat(1'b1, 1'b1, 1'b1);
      check("rst_busy", i, 32'(busy), 32'd0);
      check("rst_carga", i, 32'(carga), 32'd0);
    end
    check("rst_word", 0, 32'(word_out), 32'h0);
    beat(1'b0, 1'b1, 1'b1);
    check("post_rst_busy", 0, 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
